// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I fetch stage.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: DEPTH-entry circular buffer of {pc, instr} with push/pop/flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wr_entry,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW:0]   OCC_ONE = (PW + 1)'(1);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else if (flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + OCC_ONE;
                2'b01:   occupancy <= occupancy - OCC_ONE;
                default: occupancy <= occupancy;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: PC register, ROM addressing, prefetch queue and redirect handling.
// Optional misaligned-redirect trap enabled by defining MISALIGN_TRAP_EN.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_data,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    input  logic                     out_ready,
    output logic                     fetch_fault,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] OCC_FULL = CW'(DEPTH);

    logic [31:0]  fetch_pc;
    logic [31:0]  redirect_target;
    logic         fault_halt;
    logic         push;
    logic         pop;
    fetch_entry_t wr_entry;
    fetch_entry_t head;

    assign imem_addr = fetch_pc;
    assign out_valid = (occupancy != '0);
    assign pop       = out_valid && out_ready;
    assign push      = !redirect_valid && !fault_halt && ((occupancy < OCC_FULL) || pop);

`ifdef MISALIGN_TRAP_EN
    assign redirect_target = redirect_pc;

    // Halt persists until a redirect lands on an aligned target.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fault_halt <= 1'b0;
        end else if (redirect_valid) begin
            fault_halt <= (redirect_pc[1:0] != 2'b00);
        end
    end
`else
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign redirect_target      = {redirect_pc[31:2], 2'b00};
    assign fault_halt           = 1'b0;
`endif

    assign fetch_fault = fault_halt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_target;
        end else if (push) begin
            fetch_pc <= fetch_pc + PC_STEP;
        end
    end

    assign wr_entry.pc    = fetch_pc;
    assign wr_entry.instr = imem_data;

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .wr_entry  (wr_entry),
        .head      (head),
        .occupancy (occupancy)
    );

    assign out_instr = head.instr;
    assign out_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit against a queue-based fetch model.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready = 1'b0;
    logic        fetch_fault;
    logic [$clog2(DEPTH):0] occupancy;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .fetch_fault    (fetch_fault),
        .occupancy      (occupancy)
    );

    logic [31:0] rom [64];

    function automatic logic [31:0] rom_f(input logic [31:0] a);
        if (a[31:8] == 24'h0) return rom[a[7:2]];
        return {a[31:2], 2'b01} ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_data = rom_f(imem_addr);

    // Reference model: queued entries, next fetch address, halt flag; sbq holds expected transfers.
    fetch_entry_t mq[$];
    fetch_entry_t sbq[$];
    logic [31:0]  mpc = RESET_PC;
    bit           mhalt = 1'b0;
    int           total = 0;
    int           bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit rv, input logic [31:0] rpc, input bit rdy);
        fetch_entry_t e;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("occupancy", 32'(occupancy), mq.size());
        chk("imem_addr", imem_addr, mpc);
        chk("fetch_fault", 32'(fetch_fault), 32'(mhalt));
        if (mq.size() > 0 && rdy) sbq.push_back(mq.pop_front());
        if (rv) begin
            mq.delete();
            if (TRAP && rpc[1:0] != 2'b00) begin
                mhalt = 1'b1;
                mpc   = rpc;
            end else begin
                mhalt = 1'b0;
                mpc   = {rpc[31:2], 2'b00};
            end
        end else if (!mhalt && mq.size() < DEPTH) begin
            e.pc    = mpc;
            e.instr = rom_f(mpc);
            mq.push_back(e);
            mpc = mpc + 32'd4;
        end
        @(negedge clk);
    endtask

    task automatic reset_check();
        reset_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_occupancy", 32'(occupancy), 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_fetch_fault", 32'(fetch_fault), 32'h0);
        chk("rst_imem_addr", imem_addr, RESET_PC);
        chk("sb_drained", sbq.size(), 32'h0);
        mq.delete();
        sbq.delete();
        mpc   = RESET_PC;
        mhalt = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin : monitor
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            #3;
            if (reset_n && out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL xfer_unexpected: got pc %h instr %h, want no transfer", out_pc, out_instr);
                end else begin
                    e = sbq.pop_front();
                    chk("xfer_pc", out_pc, e.pc);
                    chk("xfer_instr", out_instr, e.instr);
                end
            end
        end
    end

    initial begin : driver
        logic [31:0] rpc;
        for (int i = 0; i < 64; i++) rom[i] = $urandom;
        rom[0] = 32'h0011_0233;
        rom[1] = 32'h4011_02B3;

        @(negedge clk);
        reset_check();
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1);

        reset_check();
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0);
        chk("stall_imem_addr", imem_addr, 32'h8);
        chk("stall_occupancy", 32'(occupancy), 32'd2);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h74, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1);

        cycle(1'b1, 32'hFFFF_FFF8, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1);

        cycle(1'b1, 32'h13, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b1, 32'h10, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       rpc = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                1:       rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
                2:       rpc = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
                default: rpc = $urandom;
            endcase
            cycle($urandom_range(0, 9) == 0, rpc, $urandom_range(0, 3) != 0);
        end

        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0);
        reset_check();
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0);
        #5;
        chk("sb_empty_end", sbq.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
